// File: rtl/mux21_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter:
// grant-state encodings and default parameter values.
package mux21_arbiter_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mux21_arbiter_muxw21.sv
// WIDTH-bit 2:1 multiplexer: y = s ? b : a.
module muxw21
  import mux21_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mux21_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux path between two requesters, with a
// registered valid/ready output. ARB_BURST_LIMIT_EN adds a per-grant burst cap.
module mux21_arbiter
  import mux21_arbiter_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("mux21_arbiter: MAX_BURST must be in 1..255");
  end

  arb_state_e       state_q, state_d;
  logic             lp_q, lp_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] mux_y;
  logic             can_take;
  logic             accept;
  logic             force_handover;

`ifdef ARB_BURST_LIMIT_EN
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  logic [7:0] cnt_q, cnt_d;
`endif

  assign gnt0      = (state_q == ST_G0);
  assign gnt1      = (state_q == ST_G1);
  assign sel       = gnt1;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  muxw21 #(.WIDTH(WIDTH)) u_mux (
    .a (d0),
    .b (d1),
    .s (sel),
    .y (mux_y)
  );

  always_comb begin
    can_take = !out_valid_q || out_ready;
    accept   = ((gnt0 && req0) || (gnt1 && req1)) && can_take;

`ifdef ARB_BURST_LIMIT_EN
    // The cap is hit on the edge that accepts the last beat, so the next owner
    // starts transferring the very next cycle.
    force_handover = accept && (cnt_q == BURST_LAST);
`else
    force_handover = 1'b0;
`endif

    state_d = state_q;
    lp_d    = lp_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1)  state_d = lp_q ? ST_G0 : ST_G1;
        else if (req0)     state_d = ST_G0;
        else if (req1)     state_d = ST_G1;
      end
      ST_G0: begin
        if (!req0 || (force_handover && req1)) begin
          lp_d    = 1'b0;
          state_d = req1 ? ST_G1 : ST_IDLE;
        end
      end
      ST_G1: begin
        if (!req1 || (force_handover && req0)) begin
          lp_d    = 1'b1;
          state_d = req0 ? ST_G0 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef ARB_BURST_LIMIT_EN
    cnt_d = cnt_q;
    if (state_d != state_q)  cnt_d = 8'd0;
    else if (force_handover) cnt_d = 8'd0;
    else if (accept)         cnt_d = cnt_q + 8'd1;
`endif

    out_data_d  = accept ? mux_y : out_data_q;
    out_valid_d = accept ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lp_q        <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef ARB_BURST_LIMIT_EN
      cnt_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      lp_q        <= lp_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef ARB_BURST_LIMIT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mux21_arbiter.sv
// Directed self-checking bench for mux21_arbiter (both burst-limit builds).
module tb_mux21_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] d0, d1;
  logic       gnt0, gnt1, sel;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  int tests_run = 0;
  int failures  = 0;

  mux21_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .d0        (d0),
    .d1        (d1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; d0 = 8'h00; d1 = 8'h00; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    req0 = 1'b1; d0 = 8'h3C;
    tick(); tick();
    tests_run++;
    if ({gnt0, out_valid, out_data} !== {1'b1, 1'b1, 8'h3C}) begin
      failures++;
      $display("FAIL reset_prestream got g0=%b v=%b d=%h want g0=1 v=1 d=3c", gnt0, out_valid, out_data);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({gnt0, gnt1, sel, out_valid, out_data} !== 12'h000) begin
      failures++;
      $display("FAIL reset_async got g0=%b g1=%b sel=%b v=%b d=%h want all 0",
               gnt0, gnt1, sel, out_valid, out_data);
    end
    req0 = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests_run++;
      if ({gnt0, gnt1, out_valid} !== 3'b000) begin
        failures++;
        $display("FAIL idle_no_req cyc=%0d got g0=%b g1=%b v=%b want 0 0 0", i, gnt0, gnt1, out_valid);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    out_ready = 1'b1;
    req0 = 1'b1; d0 = vals[0];
    tick();
    tests_run++;
    if ({gnt0, gnt1, sel} !== 3'b100) begin
      failures++;
      $display("FAIL single_grant got g0=%b g1=%b sel=%b want 1 0 0", gnt0, gnt1, sel);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i < 2) d0 = vals[i+1];
      else       req0 = 1'b0;
      tests_run++;
      if ({sel, out_valid, out_data} !== {1'b0, 1'b1, vals[i]}) begin
        failures++;
        $display("FAIL single_beat%0d got sel=%b v=%b d=%h want sel=0 v=1 d=%h",
                 i, sel, out_valid, out_data, vals[i]);
      end
    end
    tick();
    tests_run++;
    if ({gnt0, gnt1, out_valid} !== 3'b000) begin
      failures++;
      $display("FAIL single_release got g0=%b g1=%b v=%b want 0 0 0", gnt0, gnt1, out_valid);
    end
  endtask

  // After requester 0 was last served, simultaneous requests must favour requester 1.
  task automatic test_lp_priority();
    req0 = 1'b1; req1 = 1'b1; d0 = 8'h01; d1 = 8'h02;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    tests_run++;
    if ({gnt0, gnt1, sel} !== 3'b011) begin
      failures++;
      $display("FAIL lp_priority got g0=%b g1=%b sel=%b want 0 1 1", gnt0, gnt1, sel);
    end
    tick();
    tests_run++;
    if ({gnt0, gnt1, out_valid} !== 3'b000) begin
      failures++;
      $display("FAIL lp_release got g0=%b g1=%b v=%b want 0 0 0", gnt0, gnt1, out_valid);
    end
  endtask

  task automatic test_contention();
    rst = 1'b1; #1; rst = 1'b0;
    out_ready = 1'b1;
    req0 = 1'b1; req1 = 1'b1; d0 = 8'h0A; d1 = 8'h0B;
    tick();
    tests_run++;
    if ({gnt0, gnt1} !== 2'b10) begin
      failures++;
      $display("FAIL contention_first got g0=%b g1=%b want 1 0", gnt0, gnt1);
    end
    tick();
    req0 = 1'b0;
    tests_run++;
    if ({out_valid, out_data} !== {1'b1, 8'h0A}) begin
      failures++;
      $display("FAIL contention_beat0 got v=%b d=%h want v=1 d=0a", out_valid, out_data);
    end
    tick();
    tests_run++;
    if ({gnt0, gnt1, sel, out_valid} !== 4'b0110) begin
      failures++;
      $display("FAIL contention_handover got g0=%b g1=%b sel=%b v=%b want 0 1 1 0",
               gnt0, gnt1, sel, out_valid);
    end
    tick();
    req1 = 1'b0;
    tests_run++;
    if ({out_valid, out_data} !== {1'b1, 8'h0B}) begin
      failures++;
      $display("FAIL contention_beat1 got v=%b d=%h want v=1 d=0b", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    req1 = 1'b1; d1 = 8'hA5;
    tick();
    tick();
    d1 = 8'h5A;
    tests_run++;
    if ({gnt1, out_valid, out_data} !== {1'b1, 1'b1, 8'hA5}) begin
      failures++;
      $display("FAIL bp_first got g1=%b v=%b d=%h want 1 1 a5", gnt1, out_valid, out_data);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({gnt1, sel, out_valid, out_data} !== {3'b111, 8'hA5}) begin
        failures++;
        $display("FAIL bp_hold%0d got g1=%b sel=%b v=%b d=%h want 1 1 1 a5",
                 i, gnt1, sel, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    tick();
    req1 = 1'b0;
    tests_run++;
    if ({out_valid, out_data} !== {1'b1, 8'h5A}) begin
      failures++;
      $display("FAIL bp_resume got v=%b d=%h want v=1 d=5a", out_valid, out_data);
    end
    tick();
    tests_run++;
    if ({gnt1, out_valid} !== 2'b00) begin
      failures++;
      $display("FAIL bp_drain got g1=%b v=%b want 0 0", gnt1, out_valid);
    end
  endtask

  task automatic test_burst();
    logic       exp_g0;
    logic [7:0] exp_d;
    rst = 1'b1; #1; rst = 1'b0;
    out_ready = 1'b1;
    req0 = 1'b1; req1 = 1'b1; d0 = 8'h0F; d1 = 8'hF0;
    for (int k = 1; k <= 16; k++) begin
      tick();
`ifdef ARB_BURST_LIMIT_EN
      exp_g0 = (((k - 1) / 4) % 2) == 0;
      exp_d  = ((((k - 2) / 4) % 2) == 0) ? 8'h0F : 8'hF0;
`else
      exp_g0 = 1'b1;
      exp_d  = 8'h0F;
`endif
      tests_run++;
      if ({gnt0, gnt1, sel} !== {exp_g0, !exp_g0, !exp_g0}) begin
        failures++;
        $display("FAIL burst_grant edge=%0d got g0=%b g1=%b sel=%b want g0=%b",
                 k, gnt0, gnt1, sel, exp_g0);
      end
      if (k >= 2) begin
        tests_run++;
        if ({out_valid, out_data} !== {1'b1, exp_d}) begin
          failures++;
          $display("FAIL burst_data edge=%0d got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, exp_d);
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_lp_priority();
    test_contention();
    test_backpressure();
    test_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
